// File: rtl/rv_fwd_ctrl_if.sv
// Interface between the ID stage and the forwarding / load-use controller.
// The pipeline drives the ID-stage fields; the controller returns stall and mux selects.
interface rv_fwd_ctrl_if #(
    parameter int RAW   = 5,
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [RAW-1:0]   id_rs1;
    logic [RAW-1:0]   id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [RAW-1:0]   id_rd;
    logic             id_rd_wen;
    logic             id_is_load;
    logic             flush;
    logic             stall;
    logic [1:0]       fwd_sel_a;
    logic [1:0]       fwd_sel_b;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_wen, id_is_load, flush,
        input  stall, fwd_sel_a, fwd_sel_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_wen, id_is_load, flush,
        output stall, fwd_sel_a, fwd_sel_b, stall_cnt
    );
endinterface

// File: rtl/rv_fwd_ctrl.sv
// Operand-forwarding and load-use hazard controller for the 5-stage RV64 pipeline.
// Tracks rd of the EX and MEM instructions; selects are registered for use in EX.
module rv_fwd_ctrl #(
    parameter int RAW   = 5,
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    rv_fwd_ctrl_if.slave  bus
);
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EXM = 2'b01;
    localparam logic [1:0] SEL_MWB = 2'b10;

    typedef struct packed {
        logic           v;
        logic [RAW-1:0] rd;
        logic           wen;
        logic           load;
    } entry_t;

    entry_t           ex_e, mem_e;
    logic [1:0]       sel_a_q, sel_b_q;
    logic [CNT_W-1:0] cnt_q;

    logic       hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
    logic       stall_w, issue;
    logic [1:0] sel_a_nxt, sel_b_nxt;
    entry_t     ex_nxt;

    // x0 is hard-wired zero, so it never creates a dependency.
    function automatic logic hit(entry_t e, logic [RAW-1:0] rs, logic used);
        return e.v & e.wen & (e.rd == rs) & (rs != '0) & used;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hit_ex_a  = hit(ex_e,  bus.id_rs1, bus.id_rs1_used);
        hit_ex_b  = hit(ex_e,  bus.id_rs2, bus.id_rs2_used);
        hit_mem_a = hit(mem_e, bus.id_rs1, bus.id_rs1_used);
        hit_mem_b = hit(mem_e, bus.id_rs2, bus.id_rs2_used);

        stall_w = bus.id_valid & ~bus.flush & ex_e.load & (hit_ex_a | hit_ex_b);
        issue   = bus.id_valid & ~bus.flush & ~stall_w;

        // Younger producer in EX takes priority over the one in MEM.
        sel_a_nxt = SEL_RF;
        if (hit_ex_a && !ex_e.load) sel_a_nxt = SEL_EXM;
        else if (hit_mem_a)         sel_a_nxt = SEL_MWB;

        sel_b_nxt = SEL_RF;
        if (hit_ex_b && !ex_e.load) sel_b_nxt = SEL_EXM;
        else if (hit_mem_b)         sel_b_nxt = SEL_MWB;

        ex_nxt = '0;
        if (issue) ex_nxt = '{v: 1'b1, rd: bus.id_rd, wen: bus.id_rd_wen, load: bus.id_is_load};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_e    <= '0;
            mem_e   <= '0;
            sel_a_q <= SEL_RF;
            sel_b_q <= SEL_RF;
            cnt_q   <= '0;
        end else begin
            mem_e   <= ex_e;
            ex_e    <= ex_nxt;
            sel_a_q <= issue ? sel_a_nxt : SEL_RF;
            sel_b_q <= issue ? sel_b_nxt : SEL_RF;
            if (stall_w && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.stall     = stall_w;
    assign bus.fwd_sel_a = sel_a_q;
    assign bus.fwd_sel_b = sel_b_q;
    assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_rv_fwd_ctrl.sv
// Directed table-driven bench for rv_fwd_ctrl, plus counter-saturation and reset sequences.
// A narrow stall counter lets saturation be reached in a few cycles.
module tb_rv_fwd_ctrl;
    localparam int RAW   = 5;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rv_fwd_ctrl_if #(.RAW(RAW), .CNT_W(CNT_W)) bus ();

    rv_fwd_ctrl #(.RAW(RAW), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wen;
        logic       ld;
        logic       fl;
        logic       e_stall;
        logic [1:0] e_sa;
        logic [1:0] e_sb;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.id_valid    = t.v;
        bus.id_rs1      = t.rs1;
        bus.id_rs1_used = t.u1;
        bus.id_rs2      = t.rs2;
        bus.id_rs2_used = t.u2;
        bus.id_rd       = t.rd;
        bus.id_rd_wen   = t.wen;
        bus.id_is_load  = t.ld;
        bus.flush       = t.fl;
    endtask

    // Drive after negedge, check combinational stall before the edge, registered outputs after it.
    task automatic apply(input vec_t t, input string tag);
        @(negedge clk);
        drive(t);
        #2;
        check({tag, ".stall"}, 32'(bus.stall), 32'(t.e_stall));
        @(posedge clk);
        #1;
        check({tag, ".sel_a"}, 32'(bus.fwd_sel_a), 32'(t.e_sa));
        check({tag, ".sel_b"}, 32'(bus.fwd_sel_b), 32'(t.e_sb));
        check({tag, ".cnt"},   32'(bus.stall_cnt), 32'(t.e_cnt));
    endtask

    initial begin
        vec_t       t;
        logic [2:0] exp_cnt;

        //            v     rs1    u1    rs2    u2    rd     wen   ld    fl    stall sa     sb     cnt
        vecs[0]  = '{1'b1, 5'd1,  1'b1, 5'd2,  1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0}; // add x5,x1,x2
        vecs[1]  = '{1'b1, 5'd5,  1'b1, 5'd3,  1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 3'd0}; // sub x6,x5,x3
        vecs[2]  = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0}; // bubble
        vecs[3]  = '{1'b1, 5'd0,  1'b1, 5'd0,  1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0}; // addi x7
        vecs[4]  = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0}; // nop
        vecs[5]  = '{1'b1, 5'd0,  1'b1, 5'd7,  1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 3'd0}; // or x8,x0,x7
        vecs[6]  = '{1'b1, 5'd0,  1'b1, 5'd0,  1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0}; // addi x7
        vecs[7]  = '{1'b1, 5'd0,  1'b1, 5'd0,  1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0}; // addi x7
        vecs[8]  = '{1'b1, 5'd7,  1'b1, 5'd7,  1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 3'd0}; // or x8,x7,x7
        vecs[9]  = '{1'b1, 5'd1,  1'b1, 5'd0,  1'b0, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0}; // ld x9
        vecs[10] = '{1'b1, 5'd9,  1'b1, 5'd9,  1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'd1}; // add x10 stalls
        vecs[11] = '{1'b1, 5'd9,  1'b1, 5'd9,  1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 3'd1}; // add x10 issues
        vecs[12] = '{1'b1, 5'd1,  1'b1, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'd1}; // addi x0
        vecs[13] = '{1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'd1}; // add x1,x0,x0
        vecs[14] = '{1'b1, 5'd1,  1'b1, 5'd0,  1'b0, 5'd4,  1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 3'd1}; // ld x4,(x1)
        vecs[15] = '{1'b1, 5'd2,  1'b1, 5'd4,  1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'd1}; // rs2=x4 unused
        vecs[16] = '{1'b1, 5'd4,  1'b1, 5'd0,  1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 3'd1}; // load dist-2
        vecs[17] = '{1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 3'd1}; // ld x13
        vecs[18] = '{1'b1, 5'd13, 1'b1, 5'd0,  1'b0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 3'd1}; // flush beats stall
        vecs[19] = '{1'b1, 5'd13, 1'b1, 5'd0,  1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 3'd1}; // after flush

        drive('{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0});
        repeat (2) @(posedge clk);
        #1;
        check("reset.stall", 32'(bus.stall),     32'd0);
        check("reset.sel_a", 32'(bus.fwd_sel_a), 32'd0);
        check("reset.sel_b", 32'(bus.fwd_sel_b), 32'd0);
        check("reset.cnt",   32'(bus.stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Repeated load-use pairs drive the 3-bit counter into saturation.
        exp_cnt = 3'd1;
        for (int i = 0; i < 8; i++) begin
            exp_cnt = (exp_cnt == 3'd7) ? 3'd7 : exp_cnt + 3'd1;
            apply('{1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 3'(exp_cnt - ((exp_cnt == 3'd7 && i > 5) ? 3'd0 : 3'd1))},
                  $sformatf("sat%0d.ld", i));
            apply('{1'b1, 5'd15, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, exp_cnt},
                  $sformatf("sat%0d.stall", i));
            apply('{1'b1, 5'd15, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, exp_cnt},
                  $sformatf("sat%0d.issue", i));
        end

        // Reset mid-run with a load in EX and a stall condition presented.
        apply('{1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'd7}, "rst.addi");
        apply('{1'b1, 5'd21, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 3'd7}, "rst.ld");
        @(negedge clk);
        t = '{1'b1, 5'd20, 1'b1, 5'd20, 1'b1, 5'd22, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0};
        drive(t);
        #2;
        check("rst.pre_stall", 32'(bus.stall), 32'd1);
        rst = 1'b1;
        #1;
        check("rst.stall", 32'(bus.stall),     32'd0);
        check("rst.sel_a", 32'(bus.fwd_sel_a), 32'd0);
        check("rst.sel_b", 32'(bus.fwd_sel_b), 32'd0);
        check("rst.cnt",   32'(bus.stall_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst.sel_a", 32'(bus.fwd_sel_a), 32'd0);
        check("post_rst.sel_b", 32'(bus.fwd_sel_b), 32'd0);
        check("post_rst.cnt",   32'(bus.stall_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
